// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the calculator ALU path: op codes, arbiter FSM states
// and the modular round-robin index helpers.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // (p + i) mod n for p < n and i <= n, without a divider.
    function automatic int rr_add(input int p, input int i, input int n);
        int s;
        s = p + i;
        return (s >= n) ? (s - n) : s;
    endfunction

    // Requester index following cur, wrapping n-1 -> 0.
    function automatic int rr_next(input int cur, input int n);
        return rr_add(cur, 1, n);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side and ALU-side handshake signals around the arbiter.
// slave: the arbiter itself. master: whatever drives requests and models the ALU.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2
);
    // requester side
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_b;
    logic [NUM_REQ*2-1:0]          i_req_op;
    logic [NUM_REQ-1:0]            i_req_signed;
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic [DATA_WIDTH-1:0]         o_rsp_result;
    logic                          o_rsp_error;
    logic [NUM_REQ-1:0]            o_rsp_valid;
    logic [NUM_REQ-1:0]            i_rsp_ready;
    // ALU side
    logic [DATA_WIDTH-1:0]         o_alu_a;
    logic [DATA_WIDTH-1:0]         o_alu_b;
    logic [1:0]                    o_alu_op;
    logic                          o_alu_signed;
    logic                          o_alu_valid;
    logic                          i_alu_ready;
    logic [DATA_WIDTH-1:0]         i_alu_result;
    logic                          i_alu_error;
    logic                          i_alu_valid;
    logic                          o_alu_rsp_ready;
    // status
    logic                          o_busy;
    logic [$clog2(NUM_REQ)-1:0]    o_grant;

    modport slave (
        input  i_req_a, i_req_b, i_req_op, i_req_signed, i_req_valid, i_rsp_ready,
        input  i_alu_ready, i_alu_result, i_alu_error, i_alu_valid,
        output o_req_ready, o_rsp_result, o_rsp_error, o_rsp_valid,
        output o_alu_a, o_alu_b, o_alu_op, o_alu_signed, o_alu_valid, o_alu_rsp_ready,
        output o_busy, o_grant
    );

    modport master (
        output i_req_a, i_req_b, i_req_op, i_req_signed, i_req_valid, i_rsp_ready,
        output i_alu_ready, i_alu_result, i_alu_error, i_alu_valid,
        input  o_req_ready, o_rsp_result, o_rsp_error, o_rsp_valid,
        input  o_alu_a, o_alu_b, o_alu_op, o_alu_signed, o_alu_valid, o_alu_rsp_ready,
        input  o_busy, o_grant
    );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request scanning from ptr
// upward with wrap. Produces one-hot, index and an any-valid flag.
module rr_picker
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_oh,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);

    // Walk the requesters in priority order starting at ptr; first hit wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[rr_add(int'(ptr), i, NUM_REQ)]) begin
                any = 1'b1;
                grant_oh[rr_add(int'(ptr), i, NUM_REQ)] = 1'b1;
                grant_idx = IW'(rr_add(int'(ptr), i, NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the single multi-cycle ALU between NUM_REQ requesters.
// Round-robin grant, one operation in flight, operands latched at grant,
// response routed back to the granted requester only. Optional watchdog
// turns a silent ALU into an error response.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);
    localparam int GW   = $clog2(NUM_REQ);
    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_t            state;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         grant;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    alu_op_t               op_q;
    logic                  signed_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  error_q;
    logic [WD_W-1:0]       wdog;
    logic [WD_W-1:0]       wdog_inc;
    logic                  wd_hit;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [GW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  rsp_ack;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req       (bus.i_req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Watchdog fires on the last allowed ISSUE/WAIT cycle. A handshake taken
    // on that same cycle pushes the count one past the limit, so compare with
    // >= to make sure the following WAIT still times out.
    if (TIMEOUT_CYCLES > 0) begin : g_wd
        assign wd_hit = (wdog >= WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wd
        assign wd_hit = 1'b0;
    end

    // saturating increment so the counter never wraps back below the limit
    assign wdog_inc = (wdog == WD_W'(TIMEOUT_CYCLES)) ? wdog : wdog + WD_W'(1);

    // only the requester that owns the op may close the response
    assign rsp_ack = bus.i_rsp_ready[grant];

    // Arbitration FSM: grant, issue to ALU, wait for result, hand back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            signed_q <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
            wdog     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        a_q      <= bus.i_req_a[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                        b_q      <= bus.i_req_b[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                        op_q     <= alu_op_t'(bus.i_req_op[int'(pick_idx)*2 +: 2]);
                        signed_q <= bus.i_req_signed[pick_idx];
                        grant    <= pick_idx;
                        wdog     <= '0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.i_alu_ready) begin
                        wdog  <= wdog_inc;
                        state <= ST_WAIT;
                    end else if (wd_hit) begin
                        // give up without a handshake; o_alu_valid drops with the state
                        result_q <= '0;
                        error_q  <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_alu_valid) begin
                        result_q <= bus.i_alu_result;
                        error_q  <= bus.i_alu_error;
                        state    <= ST_RESP;
                    end else if (wd_hit) begin
                        result_q <= '0;
                        error_q  <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                ST_RESP: begin
                    if (rsp_ack) begin
                        rr_ptr <= GW'(rr_next(int'(grant), NUM_REQ));
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Accept is combinational in IDLE so the winner sees ready in the request cycle.
    assign bus.o_req_ready     = (state == ST_IDLE) ? pick_oh : '0;
    assign bus.o_rsp_valid     = (state == ST_RESP) ? (NUM_REQ'(1) << grant) : '0;
    assign bus.o_rsp_result    = result_q;
    assign bus.o_rsp_error     = error_q;

    assign bus.o_alu_a         = a_q;
    assign bus.o_alu_b         = b_q;
    assign bus.o_alu_op        = op_q;
    assign bus.o_alu_signed    = signed_q;
    assign bus.o_alu_valid     = (state == ST_ISSUE);
    // IDLE also accepts results so a late answer after a timeout is drained
    assign bus.o_alu_rsp_ready = (state == ST_WAIT) || (state == ST_IDLE);

    assign bus.o_busy          = (state != ST_IDLE);
    assign bus.o_grant         = grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single op, round-robin ordering, ALU error
// forwarding, watchdog timeout, response back-pressure and mid-op reset.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DW = 16;
    localparam int NR = 2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [1:0] op, input logic sgn);
        bus.i_req_a[r*DW +: DW] = a;
        bus.i_req_b[r*DW +: DW] = b;
        bus.i_req_op[r*2 +: 2]  = op;
        bus.i_req_signed[r]     = sgn;
    endtask

    // From ISSUE: ALU accepts at once, answers next cycle; leaves FSM in RESP.
    task automatic alu_1cycle(input logic [DW-1:0] res, input logic err);
        bus.i_alu_ready = 1'b1;
        tick();
        bus.i_alu_ready = 1'b0;
        chk("wait_alu_valid_low", bus.o_alu_valid, 0);
        chk("wait_rsp_ready", bus.o_alu_rsp_ready, 1);
        bus.i_alu_result = res;
        bus.i_alu_error  = err;
        bus.i_alu_valid  = 1'b1;
        tick();
        bus.i_alu_valid  = 1'b0;
    endtask

    task automatic ack(input int r);
        bus.i_rsp_ready[r] = 1'b1;
        tick();
        bus.i_rsp_ready = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_req_valid  = '0;
        bus.i_rsp_ready  = '0;
        bus.i_alu_ready  = 1'b0;
        bus.i_alu_valid  = 1'b0;
        bus.i_alu_error  = 1'b0;
        bus.i_alu_result = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL sim_timeout: observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        bus.i_req_a = '0;
        bus.i_req_b = '0;
        bus.i_req_op = '0;
        bus.i_req_signed = '0;
        do_reset();
        rst = 1'b1;
        #1;
        // --- reset state
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_grant", bus.o_grant, 0);
        chk("rst_req_ready", bus.o_req_ready, 0);
        chk("rst_rsp_valid", bus.o_rsp_valid, 0);
        chk("rst_alu_valid", bus.o_alu_valid, 0);
        chk("rst_result", bus.o_rsp_result, 0);
        chk("rst_error", bus.o_rsp_error, 0);
        chk("rst_alu_a", bus.o_alu_a, 0);
        rst = 1'b0;

        // --- single req0: 7 + 5
        set_req(0, 16'd7, 16'd5, OP_ADD, 1'b0);
        bus.i_req_valid = 2'b01;
        #1;
        chk("b_req_ready", bus.o_req_ready, 2'b01);
        tick();
        bus.i_req_valid = 2'b00;
        chk("b_alu_valid", bus.o_alu_valid, 1);
        chk("b_alu_a", bus.o_alu_a, 7);
        chk("b_alu_b", bus.o_alu_b, 5);
        chk("b_alu_op", bus.o_alu_op, OP_ADD);
        chk("b_grant", bus.o_grant, 0);
        chk("b_req_ready_issue", bus.o_req_ready, 0);
        chk("b_busy", bus.o_busy, 1);
        alu_1cycle(16'd12, 1'b0);
        chk("b_rsp_valid", bus.o_rsp_valid, 2'b01);
        chk("b_result", bus.o_rsp_result, 12);
        chk("b_error", bus.o_rsp_error, 0);
        ack(0);
        chk("b_idle_busy", bus.o_busy, 0);
        chk("b_idle_rsp_valid", bus.o_rsp_valid, 0);

        // --- both valid from reset: req0, then req1, then wrap to req0
        do_reset();
        set_req(0, 16'd3, 16'd4, OP_MUL, 1'b0);
        set_req(1, 16'd20, 16'd6, OP_SUB, 1'b0);
        bus.i_req_valid = 2'b11;
        #1;
        chk("c_ready_first", bus.o_req_ready, 2'b01);
        tick();
        chk("c_grant0", bus.o_grant, 0);
        chk("c_alu_a0", bus.o_alu_a, 3);
        chk("c_alu_op0", bus.o_alu_op, OP_MUL);
        chk("c_pending_not_ready", bus.o_req_ready, 0);
        alu_1cycle(16'd12, 1'b0);
        chk("c_rsp0", bus.o_rsp_valid, 2'b01);
        ack(0);
        chk("c_ready_second", bus.o_req_ready, 2'b10);
        tick();
        chk("c_grant1", bus.o_grant, 1);
        chk("c_alu_a1", bus.o_alu_a, 20);
        chk("c_alu_op1", bus.o_alu_op, OP_SUB);
        alu_1cycle(16'd14, 1'b0);
        chk("c_rsp1", bus.o_rsp_valid, 2'b10);
        chk("c_result1", bus.o_rsp_result, 14);
        ack(1);
        chk("c_ready_wrap", bus.o_req_ready, 2'b01);
        tick();
        bus.i_req_valid = 2'b00;
        chk("c_grant_wrap", bus.o_grant, 0);
        alu_1cycle(16'd7, 1'b0);
        ack(0);

        // --- req1 divide by zero: error forwarded, pointer moves past req1
        set_req(1, 16'd9, 16'd0, OP_DIV, 1'b1);
        bus.i_req_valid = 2'b10;
        #1;
        chk("d_ready", bus.o_req_ready, 2'b10);
        tick();
        bus.i_req_valid = 2'b00;
        chk("d_alu_op", bus.o_alu_op, OP_DIV);
        chk("d_alu_signed", bus.o_alu_signed, 1);
        chk("d_alu_b", bus.o_alu_b, 0);
        alu_1cycle(16'hDEAD, 1'b1);
        chk("d_rsp_valid", bus.o_rsp_valid, 2'b10);
        chk("d_error", bus.o_rsp_error, 1);
        chk("d_result", bus.o_rsp_result, 16'hDEAD);
        ack(1);
        set_req(0, 16'd1, 16'd1, OP_ADD, 1'b0);
        bus.i_req_valid = 2'b11;
        #1;
        chk("d_rr_advanced", bus.o_req_ready, 2'b01);
        bus.i_req_valid = 2'b00;
        #1;

        // --- watchdog: ALU never ready
        bus.i_req_valid = 2'b01;
        #1;
        tick();
        bus.i_req_valid = 2'b00;
        for (int i = 0; i < TO; i++) begin
            chk("e_issue_alu_valid", bus.o_alu_valid, 1);
            tick();
        end
        chk("e_rsp_valid", bus.o_rsp_valid, 2'b01);
        chk("e_error", bus.o_rsp_error, 1);
        chk("e_result", bus.o_rsp_result, 0);
        chk("e_alu_valid_dropped", bus.o_alu_valid, 0);
        ack(0);
        // late ALU answer is swallowed in IDLE
        bus.i_alu_result = 16'h0055;
        bus.i_alu_valid  = 1'b1;
        #1;
        chk("e_drain_ready", bus.o_alu_rsp_ready, 1);
        tick();
        bus.i_alu_valid = 1'b0;
        chk("e_drain_idle", bus.o_busy, 0);
        chk("e_drain_no_rsp", bus.o_rsp_valid, 0);

        // --- response back-pressure for 10 cycles
        set_req(0, 16'd100, 16'd23, OP_SUB, 1'b0);
        bus.i_req_valid = 2'b01;
        #1;
        chk("f_ready", bus.o_req_ready, 2'b01);
        tick();
        bus.i_req_valid = 2'b00;
        alu_1cycle(16'd77, 1'b0);
        set_req(1, 16'd2, 16'd3, OP_ADD, 1'b0);
        bus.i_req_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            chk("f_hold_rsp_valid", bus.o_rsp_valid, 2'b01);
            chk("f_hold_busy", bus.o_busy, 1);
            chk("f_hold_no_grant", bus.o_req_ready, 0);
            tick();
        end
        bus.i_rsp_ready = 2'b10;
        tick();
        bus.i_rsp_ready = 2'b00;
        chk("f_foreign_ready_ignored", bus.o_rsp_valid, 2'b01);
        chk("f_result", bus.o_rsp_result, 77);
        ack(0);
        chk("f_pending_req1", bus.o_req_ready, 2'b10);
        tick();
        bus.i_req_valid = 2'b00;
        chk("f_grant1", bus.o_grant, 1);
        bus.i_alu_ready = 1'b1;
        tick();
        bus.i_alu_ready = 1'b0;
        chk("g_in_wait", bus.o_alu_rsp_ready, 1);
        chk("g_busy", bus.o_busy, 1);

        // --- reset while waiting on the ALU
        rst = 1'b1;
        #1;
        chk("g_rst_busy", bus.o_busy, 0);
        chk("g_rst_grant", bus.o_grant, 0);
        chk("g_rst_rsp_valid", bus.o_rsp_valid, 0);
        chk("g_rst_alu_valid", bus.o_alu_valid, 0);
        chk("g_rst_result", bus.o_rsp_result, 0);
        chk("g_rst_error", bus.o_rsp_error, 0);
        tick();
        rst = 1'b0;
        set_req(0, 16'd7, 16'd5, OP_ADD, 1'b0);
        bus.i_req_valid = 2'b01;
        #1;
        chk("g_post_ready", bus.o_req_ready, 2'b01);
        tick();
        bus.i_req_valid = 2'b00;
        chk("g_post_alu_a", bus.o_alu_a, 7);
        alu_1cycle(16'd12, 1'b0);
        chk("g_post_rsp_valid", bus.o_rsp_valid, 2'b01);
        chk("g_post_result", bus.o_rsp_result, 12);
        ack(0);
        chk("g_post_idle", bus.o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
